// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states and requester ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/arb_starve_pick.sv
// Data-priority pick with a fetch anti-starvation counter; the pick is
// combinational, the counter advances only on grants made in IDLE.
module arb_starve_pick #(
    parameter int STARVE_MAX = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_req,
    input  logic d_req,
    input  logic grant,
    output logic pick_d
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt_r;
    logic          starved_s;

    // Winner selection: fetch is forced once data has won STARVE_MAX times in a row
    always_comb begin
        starved_s = (starve_cnt_r == CW'(STARVE_MAX));
        pick_d    = d_req && !(i_req && starved_s);
    end

    // Starvation counter: saturating count of D grants while fetch waits
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_r <= CW'(0);
        end else if (!i_req) begin
            starve_cnt_r <= CW'(0);
        end else if (grant && pick_d) begin
            if (!starved_s) begin
                starve_cnt_r <= starve_cnt_r + CW'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else if (grant) begin
            starve_cnt_r <= CW'(0);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the fetch port (read-only) and the
// load/store port, sequencing each access through ISSUE, WAIT and DONE.
import mem_arb_pkg::*;

module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state_r;
    logic              id_r;
    logic              we_r;
    logic [1:0]        lat_cnt_r;
    logic              grant_s;
    logic              pick_d_s;
    logic              misalign_s;
    logic [ADDR_W-1:0] addr_sel_s;

    arb_starve_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .CLK    (CLK),
        .RST    (RST),
        .i_req  (i_req),
        .d_req  (d_req),
        .grant  (grant_s),
        .pick_d (pick_d_s)
    );

    // Winner address mux; fetch byte offset is forced to zero so it never faults
    always_comb begin
        grant_s = (state_r == IDLE) && (i_req || d_req);
        if (pick_d_s) begin
            addr_sel_s = d_addr;
        end else begin
            addr_sel_s = i_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
        end
        misalign_s = (addr_sel_s[1:0] != 2'b00);
    end

    // Access sequencer with registered memory strobes, acks and read data
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            id_r      <= REQ_I;
            we_r      <= 1'b0;
            lat_cnt_r <= 2'd0;
            i_ack     <= 1'b0;
            i_rdata   <= {DATA_W{1'b0}};
            d_ack     <= 1'b0;
            d_rdata   <= {DATA_W{1'b0}};
            d_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {(ADDR_W-2){1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        id_r <= pick_d_s;
                        we_r <= pick_d_s & d_we;
                        busy <= 1'b1;
                        if (misalign_s) begin
                            state_r <= DONE;
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                        end else begin
                            state_r   <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= pick_d_s & d_we;
                            mem_addr  <= addr_sel_s[ADDR_W-1:2];
                            mem_wdata <= pick_d_s ? d_wdata : {DATA_W{1'b0}};
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (we_r) begin
                        state_r <= DONE;
                        d_ack   <= (id_r == REQ_D);
                        i_ack   <= (id_r == REQ_I);
                    end else begin
                        state_r   <= WAIT;
                        lat_cnt_r <= 2'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt_r != 2'd0) begin
                        lat_cnt_r <= lat_cnt_r - 2'd1;
                    end else begin
                        state_r <= DONE;
                        if (id_r == REQ_D) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    d_err   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    d_err   <= 1'b0;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
